// File: rtl/sr_sched_if.sv
// sr_sched_if: bundle of the requester-side and shifter-side signals of the
// round-robin shift-register scheduler.
//
//   i_req     [NREQ]   request per requester (held until granted)
//   i_data    [NREQ*W] requester n's word at i_data[n*W +: W]
//   o_gnt     [NREQ]   one-hot grant pulse, coincident with o_srload
//   o_srdata  [W]      captured word for the shift register
//   o_srload           one-cycle load strobe
//   i_srbusy           shift register is shifting
//   o_owner   [clog2]  index of the last granted requester
//   o_timeout          sticky abandoned-transfer flag
//
// Modports: slave = the scheduler, master = the surrounding environment.
interface sr_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
);
  localparam int unsigned OW = $clog2(NREQ);

  logic [NREQ-1:0]   i_req;
  logic [NREQ*W-1:0] i_data;
  logic [NREQ-1:0]   o_gnt;
  logic [W-1:0]      o_srdata;
  logic              o_srload;
  logic              i_srbusy;
  logic [OW-1:0]     o_owner;
  logic              o_timeout;

  modport slave (
    input  i_req, i_data, i_srbusy,
    output o_gnt, o_srdata, o_srload, o_owner, o_timeout
  );

  modport master (
    output i_req, i_data, i_srbusy,
    input  o_gnt, o_srdata, o_srload, o_owner, o_timeout
  );
endinterface

// File: rtl/sr_sched.sv
// sr_sched: round-robin scheduler sharing one output shift register between
// NREQ requesters. In IDLE it picks a requester (scan from ptr, wrapping),
// captures its word, pulses o_srload/o_gnt for one cycle, gives the shifter
// one SETTLE cycle to raise i_srbusy, then waits in WAIT for busy to fall.
// A transfer whose busy stays high for TIMEOUT WAIT cycles is abandoned and
// the sticky o_timeout flag is set.
//
// Ports:
//   i_clk   clock, all logic on the rising edge
//   i_rst   synchronous active-high reset
//   bus     sr_sched_if.slave (requests, words, grants, shifter handshake,
//           owner index, timeout flag)
//
// Configuration macro SR_SCHED_PRIO_EN: when defined, requester 0 has strict
// priority and winning through it leaves ptr unchanged; the others keep
// round-robin order. Undefined: pure round robin over all requesters.
module sr_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TW      = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic      i_clk,
  input  logic      i_rst,
  sr_sched_if.slave bus
);

  localparam int unsigned OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_ptr;
  logic [TW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [W-1:0]    r_srdata;
  logic            r_srload;
  logic [OW-1:0]   r_owner;
  logic            r_timeout;

  logic            w_found;
  logic [OW-1:0]   w_win;
  logic [OW-1:0]   w_ptr_nxt;
  logic            w_ptr_adv;
  logic [NREQ-1:0] w_gnt;
  logic [W-1:0]    w_word;
  logic [TW-1:0]   w_cnt_inc;

  // Round-robin scan: candidate index is (ptr + k) mod NREQ, computed one bit
  // wider than the index so the wrap works for non-power-of-two NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_ptr_adv = 1'b1;
    for (int unsigned k = 0; k < NREQ; k++) begin
      logic [OW:0] sum;
      sum = {1'b0, r_ptr} + (OW+1)'(k);
      if (sum >= (OW+1)'(NREQ)) begin
        sum = sum - (OW+1)'(NREQ);
      end
      if (!w_found && bus.i_req[sum[OW-1:0]]) begin
        w_found = 1'b1;
        w_win   = sum[OW-1:0];
      end
    end
`ifdef SR_SCHED_PRIO_EN
    // Requester 0 overrides the scan and does not move the pointer.
    if (bus.i_req[0]) begin
      w_found   = 1'b1;
      w_win     = '0;
      w_ptr_adv = 1'b0;
    end
`endif
  end

  // Next pointer = (winner + 1) mod NREQ.
  always_comb begin
    logic [OW:0] nxt;
    nxt = {1'b0, w_win} + (OW+1)'(1);
    if (nxt >= (OW+1)'(NREQ)) begin
      nxt = '0;
    end
    w_ptr_nxt = nxt[OW-1:0];
  end

  // One-hot grant and word mux for the winner.
  always_comb begin
    w_gnt  = '0;
    w_word = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (w_win == OW'(n)) begin
        w_gnt[n] = 1'b1;
        w_word   = bus.i_data[n*W +: W];
      end
    end
  end

  assign w_cnt_inc = r_cnt + TW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_srdata  <= '0;
      r_srload  <= 1'b0;
      r_owner   <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless IDLE issues a grant.
      r_gnt    <= '0;
      r_srload <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found && !bus.i_srbusy) begin
            r_state  <= S_LOAD;
            r_srdata <= w_word;
            r_owner  <= w_win;
            r_gnt    <= w_gnt;
            r_srload <= 1'b1;
            if (w_ptr_adv) begin
              r_ptr <= w_ptr_nxt;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.i_srbusy) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            // Compare the incremented value so the flag rises on the
            // TIMEOUT-th busy cycle in WAIT; the counter never exceeds it.
            if (w_cnt_inc == TW'(TIMEOUT)) begin
              r_timeout <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt     = r_gnt;
  assign bus.o_srdata  = r_srdata;
  assign bus.o_srload  = r_srload;
  assign bus.o_owner   = r_owner;
  assign bus.o_timeout = r_timeout;

endmodule

// File: tb/tb_sr_sched.sv
// tb_sr_sched: randomized bench for sr_sched. Requesters raise requests at
// random and drop them after their grant; the bench plays the shifter and
// holds busy for a random length after each load (including lengths around
// the timeout boundary and a long stuck-busy case). A transfer-level model
// predicts the cycle of every grant, the winner, captured word, owner and
// timeout flag. Random single-cycle resets are injected.
module tb_sr_sched;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned TW      = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int          NCYC    = 4000;
  localparam int          NEVER   = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst;

  sr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  sr_sched #(
    .NREQ(NREQ),
    .W(W),
    .TW(TW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Winner from the arbitration rule: first set request scanning from ptr.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef SR_SCHED_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] data;
  logic              busy;

  // Model state
  int              m_ptr;
  int              idle_from;
  int              busy_until;
  int              timeout_at;
  logic            m_to;
  logic [W-1:0]    m_data;
  int              m_owner;
  logic [NREQ-1:0] exp_gnt;

  initial begin
    rst  = 1'b1;
    req  = '1;
    data = {$urandom, $urandom};
    busy = 1'b0;
    bus.i_req    = req;
    bus.i_data   = data;
    bus.i_srbusy = busy;

    m_ptr      = 0;
    idle_from  = NEVER;
    busy_until = -1;
    timeout_at = -1;
    m_to       = 1'b0;
    m_data     = '0;
    m_owner    = 0;
    exp_gnt    = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == timeout_at) m_to = 1'b1;

      check("gnt",     32'(bus.o_gnt),     32'(exp_gnt));
      check("srload",  32'(bus.o_srload),  32'(exp_gnt != '0));
      check("srdata",  32'(bus.o_srdata),  32'(m_data));
      check("owner",   32'(bus.o_owner),   32'(m_owner));
      check("timeout", 32'(bus.o_timeout), 32'(m_to));

      // Load seen this cycle: requester drops, shifter picks a busy length.
      if (exp_gnt != '0) begin
        int d, r, first_low;
        req = req & ~exp_gnt;
        r = int'($urandom % 10);
        case (r)
          6:       d = TIMEOUT - 1;
          7:       d = TIMEOUT;
          8:       d = TIMEOUT + 1;
          9:       d = 40;
          default: d = r;
        endcase
        busy_until = cyc + d;
        first_low  = (cyc + 2 > cyc + d + 1) ? cyc + 2 : cyc + d + 1;
        if (first_low > cyc + 1 + TIMEOUT) begin
          idle_from  = cyc + 2 + TIMEOUT;
          timeout_at = idle_from;
        end else begin
          idle_from = first_low + 1;
        end
      end

      // Drive inputs for this cycle.
      rst  = (cyc < 2) || ($urandom % 80 == 0);
      busy = (cyc <= busy_until);
      for (int n = 0; n < NREQ; n++) begin
        if (cyc < 2) begin
          req[n] = 1'b1;
        end else if (!req[n] && !exp_gnt[n] && ($urandom % 4 == 0)) begin
          req[n] = 1'b1;
          data[n*W +: W] = W'($urandom);
        end
      end
      bus.i_req    = req;
      bus.i_data   = data;
      bus.i_srbusy = busy;

      // Predict the next cycle.
      if (rst) begin
        m_ptr      = 0;
        m_to       = 1'b0;
        m_data     = '0;
        m_owner    = 0;
        exp_gnt    = '0;
        timeout_at = -1;
        idle_from  = cyc + 1;
      end else if (cyc >= idle_from && req != '0 && !busy) begin
        int w;
        w       = pick(req, m_ptr);
        exp_gnt = '0;
        exp_gnt[w] = 1'b1;
        m_data  = data[w*W +: W];
        m_owner = w;
`ifdef SR_SCHED_PRIO_EN
        if (w != 0) m_ptr = (w + 1) % NREQ;
`else
        m_ptr = (w + 1) % NREQ;
`endif
        idle_from = NEVER;
      end else begin
        exp_gnt = '0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
